uart_tx_arbiter: RTL and testbench

Shares the single 8N1 UART transmit line between N_REQ message sources (sensor readout, status, command echo). The block grants one source at a time, round-robin, and holds that grant for a whole multi-byte message. It serialises bytes at the CLK_DIV baud period: 434 cycles at 50 MHz, about 115200 baud. A gap timeout stops a stalled source from locking out the others.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_bit_timer.sv | 17 +
 rtl/uart_tx_arbiter.sv | 121 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the transmitter state encoding
package uart_pkg;
  localparam int CLK_DIV_115200 = 434;
  localparam int UART_FRAME_BITS = 10;
  localparam int GAP_TIMEOUT_DEFAULT = 6944;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: enable-gated baud counter, pulses bit_done on the last cycle of each bit
module uart_bit_timer #(
  parameter int CLK_DIV = 434
) (
  input  logic clk_50M,
  input  logic rst,
  input  logic en,
  output logic bit_done
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt_q;
  assign bit_done = en && (cnt_q == CW'(CLK_DIV - 1));
  // count 0..CLK_DIV-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk_50M)
    if (rst || !en) cnt_q <= '0;
    else cnt_q <= bit_done ? '0 : cnt_q + CW'(1);
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-locked sharing of one 8N1 UART transmit line
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CLK_DIV = CLK_DIV_115200,
  parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEFAULT,
  localparam int GW = $clog2(N_REQ)
) (
  input  logic               clk_50M,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               tx,
  output logic               busy,
  output logic [GW-1:0]      grant_id
);
  localparam int GCW = $clog2(GAP_TIMEOUT + 1);
  state_t state_q, state_d;
  logic [GW-1:0] grant_q, grant_d, rr_q, rr_d, pick, idx, rr_next;
  logic [GCW-1:0] gap_q, gap_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic last_q, last_d, tx_q, tx_d, bit_done;
  uart_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_50M (clk_50M),
    .rst     (rst),
    .en      (state_q == START || state_q == DATA || state_q == STOP),
    .bit_done(bit_done)
  );
  assign req_ready = (state_q == LOAD) ? N_REQ'(1) << grant_q : '0;
  assign tx = tx_q;
  assign busy = state_q != IDLE;
  assign grant_id = grant_q;
  assign rr_next = GW'((int'(grant_q) + 1) % N_REQ);
  // first valid source at or after rr_ptr, wrapping; lowest offset wins
  always_comb begin
    pick = rr_q;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = GW'((int'(rr_q) + i) % N_REQ);
      if (req_valid[idx]) pick = idx;
    end
  end
  // arbitration, lock, gap timeout and serialiser next state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d = rr_q;
    gap_d = gap_q;
    shift_d = shift_q;
    last_d = last_q;
    bit_cnt_d = bit_cnt_q;
    tx_d = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        gap_d = '0;
        if (|req_valid) begin
          grant_d = pick;
          state_d = LOAD;
        end
      end
      LOAD:
        if (req_valid[grant_q]) begin
          shift_d = req_data[8*grant_q +: 8];
          last_d = req_last[grant_q];
          gap_d = '0;
          bit_cnt_d = '0;
          tx_d = 1'b0;
          state_d = START;
        end else if (gap_q == GCW'(GAP_TIMEOUT - 1)) begin
          gap_d = '0;
          rr_d = rr_next;
          state_d = IDLE;
        end else gap_d = gap_q + GCW'(1);
      START:
        if (bit_done) begin
          tx_d = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = DATA;
        end
      DATA:
        if (bit_done) begin
          tx_d = (bit_cnt_q == 3'd7) ? 1'b1 : shift_q[0];
          shift_d = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d = (bit_cnt_q == 3'd7) ? STOP : DATA;
        end
      STOP:
        if (bit_done) begin
          rr_d = last_q ? rr_next : rr_q;
          state_d = last_q ? IDLE : LOAD;
        end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset aborts any frame in flight
  always_ff @(posedge clk_50M)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q <= '0;
      gap_q <= '0;
      shift_q <= '0;
      last_q <= 1'b0;
      bit_cnt_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      gap_q <= gap_d;
      shift_q <= shift_d;
      last_q <= last_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for the shared UART transmitter
module tb_uart_tx_arbiter;
  import uart_pkg::*;
  localparam int N = 4;
  localparam int CD = CLK_DIV_115200;
  localparam int GT = GAP_TIMEOUT_DEFAULT;
  logic clk_50M = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_last = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0] req_ready;
  logic tx, busy;
  logic [1:0] grant_id;
  int checks = 0;
  int passes = 0;
  uart_tx_arbiter #(.N_REQ(N), .CLK_DIV(CD), .GAP_TIMEOUT(GT)) dut (
    .clk_50M  (clk_50M),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id)
  );
  always #10 clk_50M = ~clk_50M;
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50M);
      #2;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic frame(input string tag, input logic [7:0] b);
    logic e;
    int bad_tx = -1;
    logic ok_b = 1'b1;
    logic ok_r = 1'b1;
    for (int k = 0; k < UART_FRAME_BITS; k++) begin
      e = (k == 0) ? 1'b0 : (k == UART_FRAME_BITS - 1) ? 1'b1 : b[(k + 7) % 8];
      for (int c = 0; c < CD; c++) begin
        if (tx !== e && bad_tx < 0) bad_tx = k * CD + c;
        if (busy !== 1'b1) ok_b = 1'b0;
        if (req_ready !== '0) ok_r = 1'b0;
        step(1);
      end
    end
    chk({tag, " first bad tx cycle"}, bad_tx, -1);
    chk({tag, " busy in frame"}, ok_b, 1'b1);
    chk({tag, " ready low in frame"}, ok_r, 1'b1);
  endtask
  initial begin
    logic ok;
    step(2);
    chk("rst tx", tx, 1'b1);
    chk("rst busy", busy, 1'b0);
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if (tx !== 1'b1 || req_ready !== '0 || busy !== 1'b0 || grant_id !== 2'd0) ok = 1'b0;
      step(1);
    end
    chk("idle quiet 10000", ok, 1'b1);
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h53;
    req_last[0] = 1'b1;
    step(1);
    chk("single grant", grant_id, 2'd0);
    chk("single busy", busy, 1'b1);
    chk("single ready", req_ready, 4'b0001);
    chk("single load tx", tx, 1'b1);
    step(1);
    req_valid = '0;
    frame("single S", 8'h53);
    chk("single busy fall", busy, 1'b0);
    chk("single idle tx", tx, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    req_valid = 4'b0101;
    req_last = 4'b0101;
    req_data[7:0] = 8'hA5;
    req_data[23:16] = 8'h3C;
    step(1);
    chk("rr first grant", grant_id, 2'd0);
    chk("rr first ready", req_ready, 4'b0001);
    step(1);
    frame("rr src0", 8'hA5);
    chk("rr idle between", busy, 1'b0);
    step(1);
    chk("rr second grant", grant_id, 2'd2);
    chk("rr second ready", req_ready, 4'b0100);
    step(1);
    frame("rr src2", 8'h3C);
    step(1);
    chk("rr wrap grant", grant_id, 2'd0);
    req_valid = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    req_valid = 4'b1010;
    req_last = 4'b0000;
    req_data[15:8] = 8'h4D;
    req_data[31:24] = 8'h11;
    step(1);
    chk("lock grant", grant_id, 2'd1);
    chk("lock ready", req_ready, 4'b0010);
    step(1);
    req_data[15:8] = 8'h30;
    frame("lock M", 8'h4D);
    chk("lock gap busy", busy, 1'b1);
    chk("lock gap tx", tx, 1'b1);
    chk("lock gap ready", req_ready, 4'b0010);
    step(1);
    req_data[15:8] = 8'h32;
    req_last[1] = 1'b1;
    frame("lock 0", 8'h30);
    chk("lock gap2 ready", req_ready, 4'b0010);
    step(1);
    req_valid[1] = 1'b0;
    frame("lock 2", 8'h32);
    chk("lock release busy", busy, 1'b0);
    chk("lock release ready", req_ready, 4'b0000);
    step(1);
    chk("lock next grant", grant_id, 2'd3);
    chk("lock next ready", req_ready, 4'b1000);
    req_valid = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    req_valid = 4'b1100;
    req_last = 4'b0000;
    req_data[23:16] = 8'h7E;
    step(1);
    chk("gap grant", grant_id, 2'd2);
    step(1);
    req_valid[2] = 1'b0;
    frame("gap byte", 8'h7E);
    ok = 1'b1;
    for (int i = 0; i < GT; i++) begin
      if (busy !== 1'b1 || tx !== 1'b1 || req_ready !== 4'b0100 || grant_id !== 2'd2) ok = 1'b0;
      step(1);
    end
    chk("gap held load", ok, 1'b1);
    chk("gap released", busy, 1'b0);
    chk("gap release tx", tx, 1'b1);
    step(1);
    chk("gap next grant", grant_id, 2'd3);
    chk("gap next ready", req_ready, 4'b1000);
    req_valid = '0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    req_valid[0] = 1'b1;
    req_last[0] = 1'b1;
    req_data[7:0] = 8'h96;
    step(2);
    req_valid = '0;
    step(4 * CD + 100);
    chk("midframe bit3", tx, 1'b0);
    chk("midframe busy", busy, 1'b1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("abort tx", tx, 1'b1);
    chk("abort busy", busy, 1'b0);
    chk("abort grant", grant_id, 2'd0);
    req_valid[1] = 1'b1;
    req_last[1] = 1'b1;
    req_data[15:8] = 8'h5A;
    step(1);
    chk("restart grant", grant_id, 2'd1);
    step(1);
    req_valid = '0;
    frame("restart", 8'h5A);
    chk("restart done", busy, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
